// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master arbiter.
package apb_pkg;

    // Transfer sequencing states of the APB master.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // PPROT bit meanings (AMBA APB4).
    localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
    localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

    // Default number of ACCESS cycles tolerated without PREADY.
    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last winner,
// wrapping around, and remembers the winner when the caller commits it.
module apb_rr_arbiter #(
    parameter int MASTERS = 4
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [MASTERS-1:0]           req,
    input  logic                         update,
    output logic [MASTERS-1:0]           grant,
    output logic [$clog2(MASTERS)-1:0]   grant_idx
);

    localparam int IDX_W = $clog2(MASTERS);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic             found;
    int               cand;

    // Search upward from last winner + 1 for the first active request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 1; i <= MASTERS; i++) begin
            cand = int'(last_q) + i;
            if (cand >= MASTERS) begin
                cand = cand - MASTERS;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
        last_d = update ? grant_idx : last_q;
    end

    // Last-grant pointer; reset to the top index so requester 0 leads.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            last_q <= IDX_W'(MASTERS - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// APB4 master shared by several requesters through round-robin arbitration,
// with a watchdog that terminates ACCESS phases stalled by a hung slave.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int PADDR_SIZE = 8,
    parameter int PDATA_SIZE = 8,
    parameter int MASTERS    = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                                 PCLK,
    input  logic                                 PRESET,
    input  logic [MASTERS-1:0]                   REQ,
    input  logic [MASTERS-1:0][PADDR_SIZE-1:0]   REQ_ADDR,
    input  logic [MASTERS-1:0]                   REQ_WRITE,
    input  logic [MASTERS-1:0][PDATA_SIZE-1:0]   REQ_WDATA,
    input  logic [MASTERS-1:0][PDATA_SIZE/8-1:0] REQ_STRB,
    input  logic [MASTERS-1:0][2:0]              REQ_PROT,
    output logic [MASTERS-1:0]                   ACK,
    output logic [PDATA_SIZE-1:0]                RSP_RDATA,
    output logic                                 RSP_ERR,
    output logic                                 BUSY,
    output logic                                 PSEL,
    output logic                                 PENABLE,
    output logic [PADDR_SIZE-1:0]                PADDR,
    output logic                                 PWRITE,
    output logic [PDATA_SIZE-1:0]                PWDATA,
    output logic [PDATA_SIZE/8-1:0]              PSTRB,
    output logic [2:0]                           PPROT,
    input  logic [PDATA_SIZE-1:0]                PRDATA,
    input  logic                                 PREADY,
    input  logic                                 PSLVERR
);

    localparam int STRB_W = PDATA_SIZE / 8;
    localparam int IDX_W  = $clog2(MASTERS);
    localparam int WD_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    apb_state_e               state_q, state_d;
    logic [MASTERS-1:0]       win_q, win_d;
    logic                     psel_q, psel_d;
    logic                     penable_q, penable_d;
    logic [PADDR_SIZE-1:0]    paddr_q, paddr_d;
    logic                     pwrite_q, pwrite_d;
    logic [PDATA_SIZE-1:0]    pwdata_q, pwdata_d;
    logic [STRB_W-1:0]        pstrb_q, pstrb_d;
    logic [2:0]               pprot_q, pprot_d;
    logic [MASTERS-1:0]       ack_q, ack_d;
    logic [PDATA_SIZE-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;
    logic [WD_W-1:0]          wd_q, wd_d;

    logic [MASTERS-1:0]       grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     arb_update;
    logic                     wd_expired;

    apb_rr_arbiter #(
        .MASTERS (MASTERS)
    ) u_arb (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (REQ),
        .update    (arb_update),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Watchdog fires on the TIMEOUT-th ACCESS cycle without PREADY.
    assign wd_expired = (TIMEOUT > 0) && (int'(wd_q) == TIMEOUT - 1);

    // Next-state, field latching and response generation.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        pprot_d    = pprot_q;
        wd_d       = wd_q;
        ack_d      = '0;
        rdata_d    = '0;
        err_d      = 1'b0;
        arb_update = 1'b0;

        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    arb_update = 1'b1;
                    win_d      = grant;
                    paddr_d    = REQ_ADDR[grant_idx];
                    pwrite_d   = REQ_WRITE[grant_idx];
                    pwdata_d   = REQ_WDATA[grant_idx];
                    pstrb_d    = REQ_WRITE[grant_idx] ? REQ_STRB[grant_idx] : '0;
                    pprot_d    = REQ_PROT[grant_idx];
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                wd_d      = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    ack_d     = win_q;
                    rdata_d   = pwrite_q ? '0 : PRDATA;
                    err_d     = PSLVERR;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    wd_d      = '0;
                    state_d   = IDLE;
                end else if (wd_expired) begin
                    // Abandon the stalled transfer and report it as an error.
                    ack_d     = win_q;
                    err_d     = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    wd_d      = '0;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                wd_d      = '0;
                state_d   = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, latched APB fields and response registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            win_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            wd_q      <= wd_d;
        end
    end

    assign ACK       = ack_q;
    assign RSP_RDATA = rdata_q;
    assign RSP_ERR   = err_q;
    assign BUSY      = busy_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: table of single transfers plus
// hand-written round-robin, watchdog and reset-during-ACCESS sequences.
module tb_apb_master_arb;
    import apb_pkg::*;

    logic                 PCLK;
    logic                 PRESET;
    logic [3:0]           REQ;
    logic [3:0][7:0]      REQ_ADDR;
    logic [3:0]           REQ_WRITE;
    logic [3:0][7:0]      REQ_WDATA;
    logic [3:0][0:0]      REQ_STRB;
    logic [3:0][2:0]      REQ_PROT;
    logic [3:0]           ACK;
    logic [7:0]           RSP_RDATA;
    logic                 RSP_ERR;
    logic                 BUSY;
    logic                 PSEL;
    logic                 PENABLE;
    logic [7:0]           PADDR;
    logic                 PWRITE;
    logic [7:0]           PWDATA;
    logic [0:0]           PSTRB;
    logic [2:0]           PPROT;
    logic [7:0]           PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_master_arb #(
        .PADDR_SIZE (8),
        .PDATA_SIZE (8),
        .MASTERS    (4),
        .TIMEOUT    (8)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .REQ       (REQ),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WRITE (REQ_WRITE),
        .REQ_WDATA (REQ_WDATA),
        .REQ_STRB  (REQ_STRB),
        .REQ_PROT  (REQ_PROT),
        .ACK       (ACK),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .BUSY      (BUSY),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int         m;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       strb;
        logic [2:0] prot;
        int         waits;
        logic [7:0] prdata;
        logic       slverr;
        logic [7:0] exp_rdata;
        logic       exp_err;
        logic       exp_pstrb;
    } txn_t;

    txn_t vecs[4];

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One transfer from an idle DUT, checking every phase.
    task automatic run_txn(input txn_t t);
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << t.m;
        REQ = '0;
        REQ[t.m]       = 1'b1;
        REQ_ADDR[t.m]  = t.addr;
        REQ_WRITE[t.m] = t.wr;
        REQ_WDATA[t.m] = t.wdata;
        REQ_STRB[t.m]  = t.strb;
        REQ_PROT[t.m]  = t.prot;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        tick();
        chk("setup_psel",    PSEL,    1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_paddr",   PADDR,   t.addr);
        chk("setup_pwrite",  PWRITE,  t.wr);
        chk("setup_pwdata",  PWDATA,  t.wdata);
        chk("setup_pstrb",   PSTRB,   t.exp_pstrb);
        chk("setup_pprot",   PPROT,   t.prot);
        chk("setup_busy",    BUSY,    1);
        tick();
        for (int k = 0; k <= t.waits; k++) begin
            chk("access_psel",    PSEL,    1);
            chk("access_penable", PENABLE, 1);
            chk("access_ack",     ACK,     0);
            chk("access_pstrb",   PSTRB,   t.exp_pstrb);
            chk("access_paddr",   PADDR,   t.addr);
            PREADY  = (k == t.waits);
            PRDATA  = (k == t.waits) ? t.prdata : 8'hEE;
            PSLVERR = (k == t.waits) ? t.slverr : 1'b0;
            tick();
        end
        chk("ack_vec",     ACK,       exp_ack);
        chk("ack_rdata",   RSP_RDATA, t.exp_rdata);
        chk("ack_err",     RSP_ERR,   t.exp_err);
        chk("ack_psel",    PSEL,      0);
        chk("ack_penable", PENABLE,   0);
        chk("ack_busy",    BUSY,      0);
        REQ     = '0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 8'h00;
        tick();
        chk("post_ack",   ACK,       0);
        chk("post_rdata", RSP_RDATA, 0);
        chk("post_err",   RSP_ERR,   0);
        chk("post_busy",  BUSY,      0);
    endtask

    initial begin
        int         order[$];
        int         rr[4];
        int         acc;
        int         cyc;
        logic [3:0] ackd;

        vecs[0] = '{1, 1'b1, 8'h40, 8'hA5, 1'b1, 3'b000, 0, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[1] = '{0, 1'b0, 8'h10, 8'h5A, 1'b1, PPROT_PRIVILEGED, 3, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{2, 1'b1, 8'h81, 8'h0F, 1'b1, PPROT_NONSECURE, 0, 8'h99, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{3, 1'b0, 8'hFE, 8'h11, 1'b1, PPROT_INSTRUCTION | PPROT_PRIVILEGED, 1, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0};

        REQ = '0; REQ_ADDR = '0; REQ_WRITE = '0; REQ_WDATA = '0;
        REQ_STRB = '0; REQ_PROT = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        PRESET = 1'b1;
        tick();
        tick();
        chk("rst_psel",    PSEL,      0);
        chk("rst_penable", PENABLE,   0);
        chk("rst_busy",    BUSY,      0);
        chk("rst_ack",     ACK,       0);
        chk("rst_rdata",   RSP_RDATA, 0);
        chk("rst_err",     RSP_ERR,   0);
        chk("rst_paddr",   PADDR,     0);
        chk("rst_pwdata",  PWDATA,    0);
        chk("rst_pwrite",  PWRITE,    0);
        chk("rst_pstrb",   PSTRB,     0);
        chk("rst_pprot",   PPROT,     0);
        PRESET = 1'b0;
        tick();

        // Table of single transfers.
        for (int v = 0; v < 4; v++) begin
            run_txn(vecs[v]);
        end

        // Round-robin with all requesters active.
        for (int i = 0; i < 4; i++) begin
            REQ_ADDR[i]  = 8'(8'h20 + i);
            REQ_WRITE[i] = 1'b1;
            REQ_WDATA[i] = 8'(i);
            REQ_STRB[i]  = 1'b1;
            REQ_PROT[i]  = 3'b000;
            rr[i] = -1;
        end
        PREADY = 1'b1;
        PRDATA = 8'h00;
        REQ = 4'hF;
        cyc = 0;
        while (order.size() < 8 && cyc < 80) begin
            tick();
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (rr[i] > 0) begin
                    rr[i]--;
                    if (rr[i] == 0) begin
                        REQ[i] = 1'b1;
                        rr[i]  = -1;
                    end
                end
            end
            ackd = ACK;
            for (int i = 0; i < 4; i++) begin
                if (ackd[i]) begin
                    order.push_back(i);
                    REQ[i] = 1'b0;
                    rr[i]  = 2;
                end
            end
        end
        REQ = '0;
        chk("rr_count", order.size(), 8);
        for (int k = 0; k < order.size() && k < 8; k++) begin
            chk("rr_order", order[k], k % 4);
        end
        tick();
        PREADY = 1'b0;
        tick();
        chk("rr_idle", BUSY, 0);

        // Watchdog on a slave that never raises PREADY.
        REQ = '0;
        REQ[2]       = 1'b1;
        REQ_ADDR[2]  = 8'h22;
        REQ_WRITE[2] = 1'b0;
        REQ_STRB[2]  = 1'b1;
        PREADY = 1'b0;
        PRDATA = 8'hFF;
        tick();
        tick();
        acc = 0;
        cyc = 0;
        while (ACK == 4'b0000 && cyc < 40) begin
            if (PENABLE) acc++;
            tick();
            cyc++;
        end
        chk("to_ack",       ACK,       4'b0100);
        chk("to_cycles",    acc,       8);
        chk("to_err",       RSP_ERR,   1);
        chk("to_rdata",     RSP_RDATA, 0);
        chk("to_penable",   PENABLE,   0);
        REQ = '0;
        PRDATA = 8'h00;
        tick();
        run_txn(vecs[0]);

        // Reset while in ACCESS, then a 0-vs-3 tie.
        REQ = '0;
        REQ[1]       = 1'b1;
        REQ_ADDR[1]  = 8'h55;
        REQ_WRITE[1] = 1'b1;
        PREADY = 1'b0;
        tick();
        tick();
        tick();
        PRESET = 1'b1;
        tick();
        chk("rstm_psel",    PSEL,    0);
        chk("rstm_penable", PENABLE, 0);
        chk("rstm_busy",    BUSY,    0);
        chk("rstm_ack",     ACK,     0);
        PRESET = 1'b0;
        REQ = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstm_noack", ACK, 0);
        end
        REQ_ADDR[0] = 8'h0A;
        REQ_ADDR[3] = 8'h3A;
        REQ = 4'b1001;
        tick();
        chk("tie_paddr", PADDR, 8'h0A);
        PREADY = 1'b1;
        tick();
        tick();
        chk("tie_ack", ACK, 4'b0001);
        REQ = '0;
        PREADY = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
